// File: rtl/l298n_pwm_multi_if.sv
`timescale 1ns/1ps
// l298n_pwm_multi_if
// Avalon-MM slave bus for the L298N PWM controller (no waitrequest).
//   address   : word address, ADDR_W bits
//   write     : write strobe, writedata is captured on the clk edge where write=1
//   writedata : 32-bit write data
//   read      : read strobe, readdata is valid the cycle after read=1 and
//               holds until the next read
//   readdata  : 32-bit read data
// Handshake: the slave is always ready, so every cycle with write=1 or read=1
// is one complete transfer; there is no back-pressure.
interface l298n_pwm_multi_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/l298n_pwm_multi.sv
`timescale 1ns/1ps
// l298n_pwm_multi
// Multi-channel PWM controller for L298N-class H-bridges.
// Each channel has PERIOD/DUTY/CTRL/DEADTIME registers at word 4c+k, shadowed
// PERIOD/DUTY/dir that load at period boundaries, and a four-state FSM
// (IDLE, RUN, DEAD, BRAKE). A synchronised emergency stop forces all channels
// into BRAKE until software clears ESTOP_LATCH in STATUS (word NUM_CH*4).
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : Avalon-MM slave (address/write/writedata/read/readdata)
//   estop_n    : asynchronous emergency stop, active-low
//   pwm_en     : per-channel EN (PWM), registered
//   in_a, in_b : per-channel IN1/IN2, registered
//   irq        : level interrupt, high while ESTOP_LATCH=1
module l298n_pwm_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int DT_W   = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    l298n_pwm_multi_if.slave    bus,
    input  logic                estop_n,
    output logic [NUM_CH-1:0]   pwm_en,
    output logic [NUM_CH-1:0]   in_a,
    output logic [NUM_CH-1:0]   in_b,
    output logic                irq
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;
    localparam logic [1:0] ST_BRAKE = 2'd3;

    localparam int STATUS_WORD = NUM_CH * 4;

    // Software-visible registers
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  duty_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_d   [NUM_CH];
    logic [DT_W-1:0]   dt_q     [NUM_CH];
    logic [DT_W-1:0]   dt_d     [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, dir_q, dir_d, brake_q, brake_d;

    // Shadows, counters and FSM
    logic [CNT_W-1:0]  period_sh_q [NUM_CH];
    logic [CNT_W-1:0]  period_sh_d [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q       [NUM_CH];
    logic [CNT_W-1:0]  cnt_d       [NUM_CH];
    logic [DT_W-1:0]   dtc_q       [NUM_CH];
    logic [DT_W-1:0]   dtc_d       [NUM_CH];
    logic [1:0]        state_q     [NUM_CH];
    logic [1:0]        state_d     [NUM_CH];
    logic [NUM_CH-1:0] dir_sh_q, dir_sh_d, dir_act_q, dir_act_d;
    logic [NUM_CH-1:0] wrap, ld, raw;

    // Outputs and status
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d, in_a_q, in_a_d, in_b_q, in_b_d;
    logic [1:0]        est_sync_q, est_sync_d;
    logic              estop_latch_q, estop_latch_d;
    logic              estop_clr;
    logic [31:0]       readdata_q, readdata_d;

    // Address decode
    logic [NUM_CH-1:0] ch_hit;
    logic              status_hit;
    logic [1:0]        reg_k;

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        reg_k      = bus.address[1:0];
        status_hit = (int'(bus.address) == STATUS_WORD);
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = (int'(bus.address[ADDR_W-1:2]) == c);
        end
    end

    // Register file, estop latch and read mux
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            period_d[c] = period_q[c];
            duty_d[c]   = duty_q[c];
            dt_d[c]     = dt_q[c];
            en_d[c]     = en_q[c];
            dir_d[c]    = dir_q[c];
            brake_d[c]  = brake_q[c];
            if (bus.write && ch_hit[c]) begin
                case (reg_k)
                    2'd0:    period_d[c] = bus.writedata[CNT_W-1:0];
                    2'd1:    duty_d[c]   = bus.writedata[CNT_W-1:0];
                    2'd2: begin
                        en_d[c]    = bus.writedata[0];
                        dir_d[c]   = bus.writedata[1];
                        brake_d[c] = bus.writedata[2];
                    end
                    default: dt_d[c]     = bus.writedata[DT_W-1:0];
                endcase
            end
        end

        est_sync_d = {est_sync_q[0], estop_n};
        // Clearing is only honoured once the synchronised input is released.
        estop_clr = bus.write && status_hit && bus.writedata[0] && est_sync_q[1];
        // The latch samples the second synchroniser stage on the same edge that
        // stage does, so a low input sets it two edges after it is seen.
        estop_latch_d = (estop_latch_q && !estop_clr) || !est_sync_d[1];

        readdata_d = readdata_q;
        if (bus.read) begin
            readdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c]) begin
                    case (reg_k)
                        2'd0:    readdata_d[CNT_W-1:0] = period_q[c];
                        2'd1:    readdata_d[CNT_W-1:0] = duty_q[c];
                        2'd2:    readdata_d[2:0]       = {brake_q[c], dir_q[c], en_q[c]};
                        default: readdata_d[DT_W-1:0]  = dt_q[c];
                    endcase
                end
            end
            if (status_hit) begin
                readdata_d[0] = estop_latch_q;
                for (int c = 0; c < NUM_CH; c++) begin
                    readdata_d[8+c] = (state_q[c] != ST_IDLE);
                end
            end
        end
    end

    // Per-channel shadows, FSM, counter and registered outputs
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wrap[c] = (cnt_q[c] == period_sh_q[c] - CNT_W'(1));
            ld[c]   = wrap[c] || (period_sh_q[c] == '0) || (state_q[c] == ST_IDLE);

            // Shadows take the _d values so a write landing on the load cycle wins.
            period_sh_d[c] = period_sh_q[c];
            duty_sh_d[c]   = duty_sh_q[c];
            dir_sh_d[c]    = dir_sh_q[c];
            if (ld[c]) begin
                period_sh_d[c] = period_d[c];
                duty_sh_d[c]   = duty_d[c];
                dir_sh_d[c]    = dir_d[c];
            end

            state_d[c]   = state_q[c];
            dir_act_d[c] = dir_act_q[c];
            dtc_d[c]     = dtc_q[c];
            if (estop_latch_q) begin
                state_d[c] = ST_BRAKE;
            end else begin
                case (state_q[c])
                    ST_IDLE: begin
                        if (en_q[c] && !brake_q[c]) begin
                            state_d[c]   = ST_RUN;
                            dir_act_d[c] = dir_sh_q[c];
                        end
                    end
                    ST_RUN: begin
                        if (!en_q[c]) begin
                            state_d[c] = ST_IDLE;
                        end else if (brake_q[c]) begin
                            state_d[c] = ST_BRAKE;
                        end else if (ld[c] && (dir_sh_d[c] != dir_act_q[c])) begin
                            state_d[c] = ST_DEAD;
                            dtc_d[c]   = dt_q[c];
                        end
                    end
                    ST_DEAD: begin
                        if (!en_q[c]) begin
                            state_d[c] = ST_IDLE;
                        end else if (brake_q[c]) begin
                            state_d[c] = ST_BRAKE;
                        end else if (dtc_q[c] == '0) begin
                            state_d[c]   = ST_RUN;
                            dir_act_d[c] = dir_sh_q[c];
                        end else begin
                            dtc_d[c] = dtc_q[c] - DT_W'(1);
                        end
                    end
                    default: begin
                        if (!brake_q[c]) begin
                            if (en_q[c]) begin
                                state_d[c]   = ST_RUN;
                                dir_act_d[c] = dir_sh_q[c];
                            end else begin
                                state_d[c] = ST_IDLE;
                            end
                        end
                    end
                endcase
            end

            // Counter restarts at 0 on every entry into RUN.
            if ((state_d[c] != ST_RUN) || (state_q[c] != ST_RUN) ||
                (period_sh_q[c] == '0) || wrap[c]) begin
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            raw[c] = (period_sh_q[c] != '0) && (cnt_q[c] < duty_sh_q[c]);

            case (state_q[c])
                ST_RUN: begin
                    pwm_en_d[c] = raw[c];
                    in_a_d[c]   = dir_act_q[c];
                    in_b_d[c]   = !dir_act_q[c];
                end
                ST_DEAD: begin
                    pwm_en_d[c] = 1'b0;
                    in_a_d[c]   = dir_act_q[c];
                    in_b_d[c]   = !dir_act_q[c];
                end
                ST_BRAKE: begin
                    pwm_en_d[c] = 1'b1;
                    in_a_d[c]   = 1'b0;
                    in_b_d[c]   = 1'b0;
                end
                default: begin
                    pwm_en_d[c] = 1'b0;
                    in_a_d[c]   = 1'b0;
                    in_b_d[c]   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                period_q[c]    <= '0;
                duty_q[c]      <= '0;
                dt_q[c]        <= '0;
                period_sh_q[c] <= '0;
                duty_sh_q[c]   <= '0;
                cnt_q[c]       <= '0;
                dtc_q[c]       <= '0;
                state_q[c]     <= ST_IDLE;
            end
            en_q          <= '0;
            dir_q         <= '0;
            brake_q       <= '0;
            dir_sh_q      <= '0;
            dir_act_q     <= '0;
            pwm_en_q      <= '0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            est_sync_q    <= 2'b11;
            estop_latch_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            period_q      <= period_d;
            duty_q        <= duty_d;
            dt_q          <= dt_d;
            period_sh_q   <= period_sh_d;
            duty_sh_q     <= duty_sh_d;
            cnt_q         <= cnt_d;
            dtc_q         <= dtc_d;
            state_q       <= state_d;
            en_q          <= en_d;
            dir_q         <= dir_d;
            brake_q       <= brake_d;
            dir_sh_q      <= dir_sh_d;
            dir_act_q     <= dir_act_d;
            pwm_en_q      <= pwm_en_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            est_sync_q    <= est_sync_d;
            estop_latch_q <= estop_latch_d;
            readdata_q    <= readdata_d;
        end
    end

    assign pwm_en       = pwm_en_q;
    assign in_a         = in_a_q;
    assign in_b         = in_b_q;
    assign irq          = estop_latch_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_l298n_pwm_multi.sv
`timescale 1ns/1ps
// Bench for l298n_pwm_multi: two channels, PERIOD/DUTY/DEADTIME behaviour,
// direction reversal, brake, emergency stop and register readback.
module tb_l298n_pwm_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int DT_W   = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              estop_n = 1'b1;
    logic [NUM_CH-1:0] pwm_en, in_a, in_b;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {pwm_en[c], in_a[c], in_b[c]} per sampled cycle
    logic [2:0] exp_q[$];

    l298n_pwm_multi_if #(.ADDR_W(ADDR_W)) bus ();

    l298n_pwm_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DT_W   (DT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .estop_n (estop_n),
        .pwm_en  (pwm_en),
        .in_a    (in_a),
        .in_b    (in_b),
        .irq     (irq)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks: called at a negedge, return at a later negedge
    task automatic bus_write(input int addr, input logic [31:0] data);
        bus.address   = ADDR_W'(addr);
        bus.writedata = data;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        bus.address = ADDR_W'(addr);
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        data        = bus.readdata;
    endtask

    task automatic wait_rise(input int c, input string tag);
        logic prev;
        bit   seen;
        prev = pwm_en[c];
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (!prev && pwm_en[c]) seen = 1'b1;
            prev = pwm_en[c];
        end
        check_eq({tag, "_rise_seen"}, 32'(seen), 32'd1);
    endtask

    // Push n samples of an ideal PWM waveform starting at phase 'start'.
    task automatic push_pwm(input int n, input int start, input int period,
                            input int duty, input logic a, input logic b);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({((start + i) % period) < duty, a, b});
        end
    endtask

    task automatic push_const(input int n, input logic [2:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Scoreboard: pop one expectation per cycle and compare channel c outputs.
    task automatic capture(input int c, input string tag);
        logic [2:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(tag, {29'd0, pwm_en[c], in_a[c], in_b[c]}, {29'd0, e});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int d;
        bus.address   = '0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        bus.read      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_pwm_en", 32'(pwm_en), 32'd0);
        check_eq("rst_in_a", 32'(in_a), 32'd0);
        check_eq("rst_in_b", 32'(in_b), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_readdata", bus.readdata, 32'd0);
        reset = 1'b0;
        bus_read(8, rd);
        check_eq("rst_status", rd, 32'd0);
        bus_read(0, rd);
        check_eq("rst_period0", rd, 32'd0);

        // ch0 PERIOD=10 DUTY=3 dir=0
        bus_write(0, 10);
        bus_write(1, 3);
        bus_write(2, 1);
        wait_rise(0, "a");
        push_pwm(20, 0, 10, 3, 1'b0, 1'b1);
        capture(0, "a_pwm_3of10");

        // DUTY=8 written in the second cycle of a period
        bus_write(1, 8);
        push_pwm(9, 1, 10, 3, 1'b0, 1'b1);
        push_pwm(20, 0, 10, 8, 1'b0, 1'b1);
        capture(0, "b_duty_shadow");

        // DUTY=0, DUTY>=PERIOD, random duty, PERIOD=0
        bus_write(1, 0);
        repeat (12) @(negedge clk);
        push_const(20, 3'b001);
        capture(0, "c_duty0");
        bus_write(1, 15);
        repeat (12) @(negedge clk);
        push_const(20, 3'b101);
        capture(0, "c_duty15");
        d = $urandom_range(1, 9);
        bus_write(1, d);
        repeat (12) @(negedge clk);
        wait_rise(0, "c_rand");
        push_pwm(20, 0, 10, d, 1'b0, 1'b1);
        capture(0, "c_duty_rand");
        bus_write(0, 0);
        repeat (12) @(negedge clk);
        push_const(20, 3'b001);
        capture(0, "c_period0");
        bus_read(0, rd);
        check_eq("c_period0_rd", rd, 32'd0);
        bus_write(0, 10);
        bus_write(1, 3);

        // ch1 direction reversal with DEADTIME=4
        bus_write(4, 10);
        bus_write(5, 3);
        bus_write(7, 4);
        bus_write(6, 1);
        wait_rise(1, "d");
        bus_write(6, 3);
        push_pwm(9, 1, 10, 3, 1'b0, 1'b1);
        push_const(5, 3'b001);
        push_pwm(10, 0, 10, 3, 1'b1, 1'b0);
        capture(1, "d_reverse");

        // Brake bit on ch0
        bus_write(2, 5);
        repeat (2) @(negedge clk);
        check_eq("brake_ch0", {29'd0, pwm_en[0], in_a[0], in_b[0]}, 32'b100);
        bus_write(2, 1);
        repeat (5) @(negedge clk);

        // One-cycle estop pulse while both channels run
        estop_n = 1'b0;
        @(negedge clk);
        check_eq("estop_irq_n1", 32'(irq), 32'd0);
        estop_n = 1'b1;
        @(negedge clk);
        check_eq("estop_irq_n2", 32'(irq), 32'd1);
        @(negedge clk);
        check_eq("estop_in_a_n3", 32'(in_a), 32'b10);
        check_eq("estop_in_b_n3", 32'(in_b), 32'b01);
        @(negedge clk);
        check_eq("estop_pwm_n4", 32'(pwm_en), 32'b11);
        check_eq("estop_in_a_n4", 32'(in_a), 32'd0);
        check_eq("estop_in_b_n4", 32'(in_b), 32'd0);

        // W1C blocked while estop_n is held low, honoured after release
        estop_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_write(8, 1);
        bus_read(8, rd);
        check_eq("w1c_blocked", rd, 32'h301);
        check_eq("w1c_blocked_irq", 32'(irq), 32'd1);
        estop_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_write(8, 1);
        bus_read(8, rd);
        check_eq("w1c_clear", rd, 32'h300);
        check_eq("w1c_clear_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("resume_in_a", 32'(in_a), 32'b10);
        check_eq("resume_in_b", 32'(in_b), 32'b01);

        // Back-to-back reads: STATUS, unmapped, CTRL ch1, then hold
        bus.read    = 1'b1;
        bus.address = 4'd8;
        @(negedge clk);
        check_eq("b2b_status", bus.readdata, 32'h300);
        bus.address = 4'd9;
        @(negedge clk);
        check_eq("b2b_unmapped", bus.readdata, 32'd0);
        bus.address = 4'd6;
        @(negedge clk);
        bus.read = 1'b0;
        check_eq("b2b_ctrl1", bus.readdata, 32'd3);
        @(negedge clk);
        check_eq("b2b_hold", bus.readdata, 32'd3);

        // Read and write to the same address in one cycle returns the old value
        bus.address   = 4'd5;
        bus.writedata = 32'd7;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        check_eq("rw_same_old", bus.readdata, 32'd3);
        bus_read(5, rd);
        check_eq("rw_same_new", rd, 32'd7);
        bus_write(5, 3);

        // Estop from IDLE, then clear back to IDLE
        bus_write(2, 0);
        bus_write(6, 0);
        repeat (3) @(negedge clk);
        estop_n = 1'b0;
        @(negedge clk);
        estop_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_estop_pwm", 32'(pwm_en), 32'b11);
        check_eq("idle_estop_in_a", 32'(in_a), 32'd0);
        bus_read(8, rd);
        check_eq("idle_estop_status", rd, 32'h301);
        repeat (2) @(negedge clk);
        bus_write(8, 1);
        repeat (3) @(negedge clk);
        check_eq("idle_after_pwm", 32'(pwm_en), 32'd0);
        check_eq("idle_after_in_b", 32'(in_b), 32'd0);
        bus_read(8, rd);
        check_eq("idle_after_status", rd, 32'd0);

        // Unused upper bits read as 0
        bus_write(2, 32'hFFFF_FFF8);
        bus_read(2, rd);
        check_eq("ctrl_upper", rd, 32'd0);
        bus_write(7, 32'hFFFF_FFFF);
        bus_read(7, rd);
        check_eq("dt_upper", rd, 32'hFF);

        // Reset mid-operation
        bus_write(2, 1);
        bus_write(6, 1);
        repeat (4) @(negedge clk);
        check_eq("pre_reset_in_b", 32'(in_b), 32'b11);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_pwm", 32'(pwm_en), 32'd0);
        check_eq("mid_reset_in_a", 32'(in_a), 32'd0);
        check_eq("mid_reset_in_b", 32'(in_b), 32'd0);
        check_eq("mid_reset_readdata", bus.readdata, 32'd0);
        reset = 1'b0;
        bus_read(6, rd);
        check_eq("post_reset_ctrl1", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
